vga_timing_pattern: RTL and testbench

//  Parametrised VGA timing generator with built-in test-pattern source. Generalises the fixed-mode
//  640x480 timing core: programmable porches/sync widths/polarities, colour width, frame/line strobes
//  and frame-synchronous pattern modes. Sits between the pixel-clock PLL and the RGB output pins.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_counter.sv | 59 +++++
 rtl/vga_timing_pattern.sv | 143 ++++++++++++++
 tb/tb_vga_timing_pattern.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA timing/pattern block.
// Holds the pattern-mode enum and the decoded-timing bundle.
package vga_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID    = 3'd0,
    PAT_BARS     = 3'd1,
    PAT_GRID     = 3'd2,
    PAT_GRADIENT = 3'd3,
    PAT_CHECKER  = 3'd4
  } mode_e;

  localparam int H_RES  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_RES  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  // Decode of the current counter position (sync flags are "active").
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic sof;
    logic eol;
    logic last;
  } tdec_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running h/v raster counters plus combinational timing decode.
// Ports: clk_i, rst_i (sync, high) in; h_o, v_o position and dec_o decode out.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int HRES  = H_RES,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP   = H_BP,
  parameter int VRES  = V_RES,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP   = V_BP,
  parameter int HSZ   = $clog2(HRES + HFP + HSYNC + HBP),
  parameter int VSZ   = $clog2(VRES + VFP + VSYNC + VBP)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic [HSZ-1:0] h_o,
  output logic [VSZ-1:0] v_o,
  output tdec_t          dec_o
);

  localparam int HTOTAL = HRES + HFP + HSYNC + HBP;
  localparam int VTOTAL = VRES + VFP + VSYNC + VBP;

  logic h_last;
  logic v_last;

  assign h_last = int'(h_o) == HTOTAL - 1;
  assign v_last = int'(v_o) == VTOTAL - 1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_o <= '0;
      v_o <= '0;
    end else if (h_last) begin
      h_o <= '0;
      v_o <= v_last ? '0 : v_o + VSZ'(1);
    end else begin
      h_o <= h_o + HSZ'(1);
    end
  end

  // Compare in 32 bits: HRES+HFP+HSYNC may equal HTOTAL
  // and not fit in HSZ bits when HBP is zero.
  always_comb begin
    dec_o      = '0;
    dec_o.de   = int'(h_o) < HRES && int'(v_o) < VRES;
    dec_o.hs   = int'(h_o) >= HRES + HFP &&
                 int'(h_o) <  HRES + HFP + HSYNC;
    dec_o.vs   = int'(v_o) >= VRES + VFP &&
                 int'(v_o) <  VRES + VFP + VSYNC;
    dec_o.sof  = h_o == '0 && v_o == '0;
    dec_o.eol  = int'(h_o) == HRES - 1 && int'(v_o) < VRES;
    dec_o.last = h_last && v_last;
  end

endmodule

// File: rtl/vga_timing_pattern.sv
// VGA timing generator with frame-synchronous test-pattern source.
// Ports: clk_i, rst_i, mode_i, color_i in; h/v count, de, syncs, sof, eol, rgb out.
module vga_timing_pattern
  import vga_pkg::*;
#(
  parameter int  HRES   = H_RES,
  parameter int  HFP    = H_FP,
  parameter int  HSYNC  = H_SYNC,
  parameter int  HBP    = H_BP,
  parameter int  VRES   = V_RES,
  parameter int  VFP    = V_FP,
  parameter int  VSYNC  = V_SYNC,
  parameter int  VBP    = V_BP,
  parameter bit  HS_POL = 1'b0,
  parameter bit  VS_POL = 1'b0,
  parameter int  CW     = 4,
  localparam int HTOTAL = HRES + HFP + HSYNC + HBP,
  localparam int VTOTAL = VRES + VFP + VSYNC + VBP,
  localparam int HSZ    = $clog2(HTOTAL),
  localparam int VSZ    = $clog2(VTOTAL)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2:0]      mode_i,
  input  logic [3*CW-1:0] color_i,
  output logic [HSZ-1:0]  hcount_o,
  output logic [VSZ-1:0]  vcount_o,
  output logic            de_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            sof_o,
  output logic            eol_o,
  output logic [CW-1:0]   r_o,
  output logic [CW-1:0]   g_o,
  output logic [CW-1:0]   b_o
);

  localparam logic [CW-1:0] MAX = '1;

  logic [HSZ-1:0] h;
  logic [VSZ-1:0] v;
  tdec_t          dec;
  mode_e          mode_q;
  logic [2:0]     bar;
  logic [CW-1:0]  pr;
  logic [CW-1:0]  pg;
  logic [CW-1:0]  pb;

  vga_timing_counter #(
    .HRES (HRES),
    .HFP  (HFP),
    .HSYNC(HSYNC),
    .HBP  (HBP),
    .VRES (VRES),
    .VFP  (VFP),
    .VSYNC(VSYNC),
    .VBP  (VBP),
    .HSZ  (HSZ),
    .VSZ  (VSZ)
  ) u_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .h_o  (h),
    .v_o  (v),
    .dec_o(dec)
  );

  // Mode only changes between frames so a pattern never tears.
  always_ff @(posedge clk_i) begin
    if (rst_i || dec.last) begin
      mode_q <= mode_e'(mode_i);
    end
  end

  assign bar = 3'(h / HSZ'(HRES / 8));

  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    if (dec.de) begin
      case (mode_q)
        PAT_SOLID: begin
          {pr, pg, pb} = color_i;
        end
        PAT_BARS: begin
          pr = {CW{~bar[1]}};
          pg = {CW{~bar[2]}};
          pb = {CW{~bar[0]}};
        end
        PAT_GRID: begin
          if (h[4:0] == 5'd0 || v[4:0] == 5'd0 ||
              int'(h) == HRES - 1 ||
              int'(v) == VRES - 1) begin
            pr = MAX;
            pg = MAX;
            pb = MAX;
          end
        end
        PAT_GRADIENT: begin
          pr = h[CW+4:5];
          pg = h[CW+4:5];
          pb = h[CW+4:5];
        end
        PAT_CHECKER: begin
          if (h[4] ^ v[4]) begin
            pr = MAX;
            pg = MAX;
            pb = MAX;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcount_o <= '0;
      vcount_o <= '0;
      de_o     <= 1'b0;
      hsync_o  <= ~HS_POL;
      vsync_o  <= ~VS_POL;
      sof_o    <= 1'b0;
      eol_o    <= 1'b0;
      r_o      <= '0;
      g_o      <= '0;
      b_o      <= '0;
    end else begin
      hcount_o <= h;
      vcount_o <= v;
      de_o     <= dec.de;
      hsync_o  <= dec.hs ? HS_POL : ~HS_POL;
      vsync_o  <= dec.vs ? VS_POL : ~VS_POL;
      sof_o    <= dec.sof;
      eol_o    <= dec.eol;
      r_o      <= pr;
      g_o      <= pg;
      b_o      <= pb;
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Scoreboard bench for vga_timing_pattern on a reduced raster.
// Expected pixels come from a behavioural raster model.
module tb_vga_timing_pattern;

  localparam int HRES  = 256;
  localparam int HFP   = 8;
  localparam int HSYNC = 16;
  localparam int HBP   = 8;
  localparam int VRES  = 40;
  localparam int VFP   = 3;
  localparam int VSYNC = 2;
  localparam int VBP   = 5;
  localparam int HT    = HRES + HFP + HSYNC + HBP;
  localparam int VT    = VRES + VFP + VSYNC + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [2:0]  mode_i = '0;
  logic [11:0] color_i = '0;
  logic [8:0]  hcount_o;
  logic [5:0]  vcount_o;
  logic        de_o, hsync_o, vsync_o, sof_o, eol_o;
  logic [3:0]  r_o, g_o, b_o;
  logic [31:0] obs;

  vga_timing_pattern #(
    .HRES(HRES), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
    .VRES(VRES), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .mode_i  (mode_i),
    .color_i (color_i),
    .hcount_o(hcount_o),
    .vcount_o(vcount_o),
    .de_o    (de_o),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .sof_o   (sof_o),
    .eol_o   (eol_o),
    .r_o     (r_o),
    .g_o     (g_o),
    .b_o     (b_o)
  );

  always #5 clk = ~clk;

  assign obs = {hcount_o, vcount_o, de_o, hsync_o, vsync_o,
                sof_o, eol_o, r_o, g_o, b_o};

  logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic [31:0] sb_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int mh = 0, mv = 0, mmode = 0;
  int cyc = 0, last_sof = -1, sof_per = 0;
  logic        cur_rst = 1'b1;
  logic [2:0]  cur_mode = '0;
  logic [11:0] cur_col = 12'h5A3;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] model_rgb(int h, int v, int m,
                                            logic [11:0] col);
    logic [3:0] g;
    if (!(h < HRES && v < VRES)) return 12'h000;
    case (m)
      0: return col;
      1: return bar_tab[h / (HRES / 8)];
      2: return (h % 32 == 0 || v % 32 == 0 || h == HRES - 1 ||
                 v == VRES - 1) ? 12'hFFF : 12'h000;
      3: begin
        g = 4'((h / 32) % 16);
        return {g, g, g};
      end
      4: return (((h / 16) % 2) != ((v / 16) % 2)) ? 12'hFFF : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [31:0] model_out(int h, int v, int m,
                                            logic [11:0] col);
    logic de, hs, vs, sof, eol;
    de  = h < HRES && v < VRES;
    hs  = !(h >= HRES + HFP && h < HRES + HFP + HSYNC);
    vs  = !(v >= VRES + VFP && v < VRES + VFP + VSYNC);
    sof = h == 0 && v == 0;
    eol = h == HRES - 1 && v < VRES;
    return {9'(h), 6'(v), de, hs, vs, sof, eol,
            model_rgb(h, v, m, col)};
  endfunction

  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    rst_i   = cur_rst;
    mode_i  = cur_mode;
    color_i = cur_col;
    if (cur_rst) begin
      e = {9'd0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
      mh = 0;
      mv = 0;
      mmode = int'(cur_mode);
    end else begin
      e = model_out(mh, mv, mmode, cur_col);
      if (mh == HT - 1 && mv == VT - 1) mmode = int'(cur_mode);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    chk("pix", obs, sb_q.pop_front());
    if (sof_o) begin
      if (last_sof >= 0) sof_per = cyc - last_sof;
      last_sof = cyc;
    end
  endtask

  task automatic expect_at(input int h, input int v,
                           input logic [11:0] rgb, input string tag);
    int  n;
    bit  hit;
    n = 0;
    hit = 0;
    while (!hit && n < 2 * FRAME) begin
      step();
      n++;
      if (int'(hcount_o) == h && int'(vcount_o) == v) hit = 1;
    end
    chk({tag, "_reach"}, 32'(hit), 32'd1);
    chk(tag, {20'd0, r_o, g_o, b_o}, {20'd0, rgb});
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, eol_h, vs_cnt, vs_h, vs_v;
    de_cnt = 0; hs_cnt = 0; hs_first = -1; eol_h = -1;
    vs_cnt = 0; vs_h = -1; vs_v = -1;

    repeat (5) step();
    chk("rst_de", 32'(de_o), 32'd0);
    chk("rst_hs", 32'(hsync_o), 32'd1);
    chk("rst_vs", 32'(vsync_o), 32'd1);
    chk("rst_rgb", {20'd0, r_o, g_o, b_o}, 32'd0);

    cur_rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME - 100) cur_mode = 3'd1;
      step();
      if (i == 0) begin
        chk("first_sof", 32'(sof_o), 32'd1);
        chk("first_de", 32'(de_o), 32'd1);
        chk("first_h", 32'(hcount_o), 32'd0);
        chk("first_rgb", {20'd0, r_o, g_o, b_o}, 32'h5A3);
      end
      if (i < HT) begin
        if (de_o) de_cnt++;
        if (!hsync_o) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = i;
        end
        if (eol_o) eol_h = int'(hcount_o);
      end
      if (!vsync_o) begin
        vs_cnt++;
        if (vs_h < 0) begin
          vs_h = int'(hcount_o);
          vs_v = int'(vcount_o);
        end
      end
    end
    chk("line_de", 32'(de_cnt), 32'(HRES));
    chk("hs_len", 32'(hs_cnt), 32'(HSYNC));
    chk("hs_start", 32'(hs_first), 32'(HRES + HFP));
    chk("eol_h", 32'(eol_h), 32'(HRES - 1));
    chk("vs_len", 32'(vs_cnt), 32'(VSYNC * HT));
    chk("vs_h", 32'(vs_h), 32'd0);
    chk("vs_v", 32'(vs_v), 32'(VRES + VFP));

    expect_at(0, 0, 12'hFFF, "bar_0");
    chk("sof_per", 32'(sof_per), 32'(FRAME));
    expect_at(32, 0, 12'hFF0, "bar_32");
    expect_at(64, 0, 12'h0FF, "bar_64");
    expect_at(255, 0, 12'h000, "bar_255");
    expect_at(270, 0, 12'h000, "bar_blank");
    cur_mode = 3'd0;

    expect_at(0, 0, 12'h5A3, "sol_0");
    expect_at(0, 5, 12'h5A3, "sol_5");
    cur_mode = 3'd2;
    expect_at(0, 20, 12'h5A3, "sol_hold");
    expect_at(100, 39, 12'h5A3, "sol_end");

    expect_at(0, 0, 12'hFFF, "grid_00");
    chk("sof_per2", 32'(sof_per), 32'(FRAME));
    expect_at(1, 1, 12'h000, "grid_11");
    expect_at(32, 1, 12'hFFF, "grid_321");
    expect_at(5, 39, 12'hFFF, "grid_last");

    expect_at(HRES + HFP + 4, 20, 12'h000, "in_hs");
    chk("in_hs_lvl", 32'(hsync_o), 32'd0);
    cur_rst = 1'b1;
    cur_mode = 3'd3;
    step();
    chk("mid_rst_hs", 32'(hsync_o), 32'd1);
    chk("mid_rst_de", 32'(de_o), 32'd0);
    cur_rst = 1'b0;
    step();
    chk("mid_sof", 32'(sof_o), 32'd1);
    chk("mid_hv", {hcount_o, vcount_o}, 32'd0);
    chk("mid_hs", 32'(hsync_o), 32'd1);
    expect_at(40, 2, 12'h111, "grad_40");
    expect_at(200, 3, 12'h666, "grad_200");

    cur_rst = 1'b1;
    cur_mode = 3'd4;
    step();
    cur_rst = 1'b0;
    expect_at(16, 0, 12'hFFF, "chk_160");
    expect_at(0, 16, 12'hFFF, "chk_016");
    expect_at(16, 16, 12'h000, "chk_1616");

    cur_rst = 1'b1;
    cur_mode = 3'd5;
    step();
    cur_rst = 1'b0;
    expect_at(10, 10, 12'h000, "m5_black");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
